// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch front end.
//   XLEN / INST_W : address and instruction widths
//   fetch_entry_t : one queued fetch result {pc, inst}
//   PC_STEP       : sequential fetch increment (one 32-bit word)
//   align_pc      : forces a redirect target onto a word boundary
package if_pkg;
  localparam int XLEN   = 32;
  localparam int INST_W = 32;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Small registered FIFO holding fetched {pc, inst} entries.
//   clk, rst      : clock, asynchronous active-low reset
//   push/push_data: write an entry at the tail
//   pop           : drop the head entry (caller guarantees non-empty)
//   flush         : synchronous clear; overrides push and pop
//   head_data     : current head entry (stale when count == 0)
//   count         : occupancy, 0..DEPTH
module fetch_fifo
  import if_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  entry_t                     push_data,
  input  logic                       pop,
  input  logic                       flush,
  output entry_t                     head_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];
  assign count     = count_q;
endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: sequential PC generation into a 1-cycle
// synchronous-read IM, capture of returned words into fetch_fifo, and
// valid/ready delivery to decode. A redirect flushes the queue, drops the
// in-flight read and restarts fetch at the (word-aligned) target.
//   clk, rst        : clock, asynchronous active-low reset
//   IM_r_addr       : IM byte address (registered PC)
//   IM_r_data       : IM data for the address of the previous cycle
//   redirect_valid  : restart request from the core
//   redirect_pc     : restart target
//   fq_valid/ready  : head-entry handshake toward decode
//   fq_pc/fq_inst   : head entry
//   fq_count        : queue occupancy
module ifetch_queue
  import if_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [31:0]                IM_r_addr,
  input  logic [31:0]                IM_r_data,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       fq_valid,
  input  logic                       fq_ready,
  output logic [31:0]                fq_pc,
  output logic [31:0]                fq_inst,
  output logic [$clog2(DEPTH+1)-1:0] fq_count
);
  localparam int            CW      = $clog2(DEPTH+1);
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);

  logic [31:0]   pc_q, req_pc_q;
  logic          req_valid_q;
  logic [CW-1:0] count;
  logic [CW:0]   credits;
  logic          issue, push, pop;
  fetch_entry_t  push_data, head;

  // A read in flight already owns a slot, so issuing only while
  // queued + in-flight < DEPTH can never overflow the queue.
  assign credits = {1'b0, count} + {{CW{1'b0}}, req_valid_q};
  assign issue   = !redirect_valid && (credits < DEPTH_C);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q        <= RESET_PC;
      req_valid_q <= 1'b0;
      req_pc_q    <= '0;
    end else if (redirect_valid) begin
      pc_q        <= align_pc(redirect_pc);
      req_valid_q <= 1'b0;
    end else if (issue) begin
      pc_q        <= pc_q + PC_STEP;
      req_valid_q <= 1'b1;
      req_pc_q    <= pc_q;
    end else begin
      req_valid_q <= 1'b0;
    end
  end

  // Response arriving in a redirect cycle belongs to the old path.
  assign push      = req_valid_q && !redirect_valid;
  assign push_data = '{pc: req_pc_q, inst: IM_r_data};
  assign fq_valid  = (count != '0) && !redirect_valid;
  assign pop       = fq_valid && fq_ready;

  fetch_fifo #(.DEPTH(DEPTH), .entry_t(fetch_entry_t)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_valid),
    .head_data (head),
    .count     (count)
  );

  assign IM_r_addr = pc_q;
  assign fq_pc     = head.pc;
  assign fq_inst   = head.inst;
  assign fq_count  = count;

  // Low bits of the target are discarded by word alignment.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];
endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;
  logic        clk, rst;
  logic [31:0] IM_r_addr, IM_r_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fq_valid, fq_ready;
  logic [31:0] fq_pc, fq_inst;
  logic [2:0]  fq_count;

  int checks = 0;
  int failures = 0;

  ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .IM_r_addr(IM_r_addr), .IM_r_data(IM_r_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fq_valid(fq_valid), .fq_ready(fq_ready), .fq_pc(fq_pc),
    .fq_inst(fq_inst), .fq_count(fq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // IM contents: word i holds 0x1000_0000 + i
  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'h1000_0000 + {18'd0, a[15:2]};
  endfunction

  // Synchronous-read SRAM, 1-cycle latency, always enabled
  initial IM_r_data = '0;
  always @(posedge clk) IM_r_data <= word(IM_r_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Stream model: decode must see consecutive word PCs starting at the
  // reset PC or the last aligned redirect target, each with its IM word.
  logic [31:0] exp_pc = 32'h0;
  always @(negedge clk) begin
    if (!rst) exp_pc = 32'h0;
    else if (redirect_valid) begin
      chk("model_valid_in_redirect", 32'(fq_valid), 32'd0);
      exp_pc = {redirect_pc[31:2], 2'b00};
    end else begin
      chk("model_valid_vs_count", 32'(fq_valid), 32'(fq_count != 3'd0));
      chk("model_count_bound", 32'(fq_count <= 3'd4), 32'd1);
      if (fq_valid) begin
        chk("model_pc", fq_pc, exp_pc);
        chk("model_inst", fq_inst, word(exp_pc));
        if (fq_ready) exp_pc = exp_pc + 32'd4;
      end
    end
  end

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; redirect_valid = 1'b0;
    next();
  endtask

  // Called with rst low at posedge+1; releases and checks the startup stream.
  task automatic startup_check();
    next();
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("st_addr", IM_r_addr, 32'(4 * k));
      chk("st_valid", 32'(fq_valid), 32'(k >= 2));
      if (k >= 2) begin
        chk("st_pc", fq_pc, 32'(4 * (k - 2)));
        chk("st_inst", fq_inst, 32'h1000_0000 + 32'(k - 2));
      end
      next();
    end
  endtask

  // Collect n handshakes within a cycle budget; they must be pc0, pc0+4, ...
  task automatic collect(input string name, input int n, input logic [31:0] pc0, input int budget);
    int got = 0;
    logic [31:0] p = pc0;
    for (int c = 0; c < budget && got < n; c++) begin
      @(negedge clk);
      if (fq_valid && fq_ready) begin
        chk({name, "_pc"}, fq_pc, p);
        chk({name, "_inst"}, fq_inst, word(p));
        p = p + 32'd4;
        got++;
      end
      next();
    end
    chk({name, "_count_in_budget"}, 32'(got), 32'(n));
  endtask

  initial begin
    rst = 1'b0; fq_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    #3;
    chk("rst_valid", 32'(fq_valid), 32'd0);
    chk("rst_count", 32'(fq_count), 32'd0);
    chk("rst_pc", fq_pc, 32'd0);
    chk("rst_inst", fq_inst, 32'd0);
    chk("rst_addr", IM_r_addr, 32'd0);

    // Startup at full throughput
    startup_check();

    // Backpressure: fill to DEPTH, then drain in order
    do_reset();
    fq_ready = 1'b0; rst = 1'b1;
    repeat (10) next();
    chk("bp_count", 32'(fq_count), 32'd4);
    chk("bp_addr", IM_r_addr, 32'h10);
    chk("bp_valid", 32'(fq_valid), 32'd1);
    fq_ready = 1'b1;
    collect("bp_drain", 5, 32'h0, 6);

    // Redirect with three queued entries and one read in flight
    do_reset();
    fq_ready = 1'b0; rst = 1'b1;
    repeat (4) next();
    chk("rd_pre_count", 32'(fq_count), 32'd3);
    redirect_valid = 1'b1; redirect_pc = 32'h200; fq_ready = 1'b1;
    @(negedge clk);
    chk("rd_valid_R", 32'(fq_valid), 32'd0);
    next();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("rd_valid_R1", 32'(fq_valid), 32'd0);
    chk("rd_count_R1", 32'(fq_count), 32'd0);
    chk("rd_addr_R1", IM_r_addr, 32'h200);
    next();
    @(negedge clk);
    chk("rd_valid_R2", 32'(fq_valid), 32'd0);
    chk("rd_addr_R2", IM_r_addr, 32'h204);
    next();
    @(negedge clk);
    chk("rd_valid_R3", 32'(fq_valid), 32'd1);
    chk("rd_pc_R3", fq_pc, 32'h200);
    chk("rd_inst_R3", fq_inst, 32'h1000_0080);
    next();

    // Misaligned then back-to-back redirect: last one wins
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    next();
    chk("b2b_align_addr", IM_r_addr, 32'h200);
    redirect_pc = 32'h400;
    next();
    redirect_valid = 1'b0;
    collect("b2b", 2, 32'h400, 5);

    // Address wrap past 2^32
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    next();
    redirect_valid = 1'b0;
    collect("wrap", 4, 32'hFFFF_FFF8, 7);
    chk("wrap_addr_after", 32'(IM_r_addr < 32'h20), 32'd1);

    // Asynchronous reset mid-burst with three entries queued
    do_reset();
    fq_ready = 1'b0; rst = 1'b1;
    repeat (4) next();
    chk("ar_pre_count", 32'(fq_count), 32'd3);
    #2 rst = 1'b0;
    #1;
    chk("ar_valid", 32'(fq_valid), 32'd0);
    chk("ar_count", 32'(fq_count), 32'd0);
    chk("ar_addr", IM_r_addr, 32'd0);
    fq_ready = 1'b1;
    @(posedge clk); #1;
    startup_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction-fetch front end between the instruction SRAM (IM1) and the OOO core's decode.
- Generates sequential fetch addresses into the synchronous-read IM, which has 1-cycle read latency and is always enabled.
- Captures returned words with their PCs in a small FIFO and delivers them to decode over a valid/ready handshake.
- On a core redirect it flushes the queue, kills the in-flight read and restarts fetch at the new PC.

Parameters:
- DEPTH, 4, queue entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- IM_r_addr  output  32  IM byte address; IM1 uses bits [15:2].
- IM_r_data  input  32  IM read data for the address presented in the previous cycle.
- redirect_valid  input  1  core redirect request (branch mispredict, exception).
- redirect_pc  input  32  redirect target.
- fq_valid  output  1  head entry valid toward decode.
- fq_ready  input  1  decode accepts the head entry.
- fq_pc  output  32  PC of the head entry.
- fq_inst  output  32  instruction of the head entry.
- fq_count  output  $clog2(DEPTH+1)  current queue occupancy.

Behaviour:
- Reset (rst=0, asynchronous, effective immediately):
  - pc_q=RESET_PC, req_valid_q=0, req_pc_q=0, queue empty.
  - fq_valid=0, fq_count=0, fq_pc=0, fq_inst=0, IM_r_addr=RESET_PC.
- Addressing: IM_r_addr = pc_q (combinational from the register). The SRAM reads every cycle; data is used only when req_valid_q=1.
- Issue condition: issue = !redirect_valid && (count_q + req_valid_q < DEPTH). This credit scheme makes overflow impossible.
- Issue cycle:
  - req_valid_q<=1, req_pc_q<=pc_q.
  - pc_q<=pc_q+4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- No-issue cycle: req_valid_q<=0 and pc_q holds.
- Response: if req_valid_q=1 and there is no redirect, push {req_pc_q, IM_r_data} into the queue that cycle.
- Output: fq_valid = (count_q!=0) && !redirect_valid. fq_pc and fq_inst are the head entry. Pop when fq_valid && fq_ready.
- Queue timing:
  - The queue is registered, so a pushed entry becomes visible the next cycle.
  - Simultaneous push and pop: count unchanged, order preserved.
  - A push into an empty queue never pops in the same cycle.
  - Pop while empty is impossible, because fq_valid=0.
- Redirect cycle R:
  - Queue flushed (count<=0), req_valid_q<=0, so the in-flight response in R is discarded.
  - pc_q<={redirect_pc[31:2],2'b00}.
  - No issue and no pop in R.
  - R+1: IM_r_addr = new PC, issue. R+2: push. R+3: fq_valid=1 with the target PC.
  - Back-to-back redirects: the last one wins; each cycle re-flushes.
- Throughput: 1 instruction per cycle when fq_ready stays high. Startup latency is issue-to-fq_valid = 2 cycles.
- Backpressure: with fq_ready=0 the queue fills to DEPTH and issue stops. There is no loss or duplication, and the order is strictly by PC.
- Reset mid-operation: all state clears asynchronously. Fetch restarts at RESET_PC on the first edge after deassertion.
- Widths: count_q+req_valid_q is evaluated at $clog2(DEPTH+1)+1 bits to avoid truncation.

Decomposition:
- Package if_pkg:
  - XLEN=32, INST_W=32.
  - typedef fetch_entry_t struct packed {logic [XLEN-1:0] pc; logic [INST_W-1:0] inst;}.
  - Constant PC_STEP=4.
- Sub-module fetch_fifo:
  - Parameters DEPTH and entry type.
  - Ports: push, push_data, pop, flush, head_data, count.
  - Synchronous flush has priority over push and pop; async active-low reset.
  - ifetch_queue holds PC/credit logic only.

Test Plan:
- Startup: release rst with RESET_PC=0, IM word i = 32'h1000_0000+i, fq_ready=1.
  - IM_r_addr = 0,4,8,... each cycle.
  - fq_valid rises 2 cycles after release with pc=0, inst=32'h1000_0000.
  - Then pc=4, inst=32'h1000_0001 on consecutive cycles.
- Backpressure: hold fq_ready=0 for 10 cycles from startup.
  - fq_count saturates at 4 and IM_r_addr stops at 32'h10.
  - On release, pops deliver pcs 0,4,8,C then 10 with no gap beyond one cycle and no duplicates.
- Redirect with full queue and read in flight: redirect_pc=32'h200 for one cycle.
  - fq_valid=0 in R, R+1 and R+2.
  - At R+3: fq_pc=32'h200, fq_inst=IM word 32'h80; no stale entries ever appear.
- Misaligned and back-to-back redirects: 32'h203 then 32'h400 on consecutive cycles.
  - The first delivered entry has pc=32'h400; pc 32'h200 never appears.
- Wrap: redirect_pc=32'hFFFF_FFF8.
  - Delivered pcs are FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Asynchronous reset mid-burst: assert rst=0 between clock edges while fq_count=3.
  - fq_valid=0, fq_count=0 and IM_r_addr=RESET_PC immediately.
  - After deassertion the startup sequence from the first scenario repeats exactly.
